sense_readout: RTL and testbench

//  Read-side controller for the 4x4 CAM/MAC bit-cell array; the complement of the row decoder that drives WL/WLB.

---
 rtl/sense_readout_if.sv | 39 +++
 rtl/sense_readout.sv | 277 +++++++++++++++++++++++++++
 tb/tb_sense_readout.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sense_readout_if.sv
// sense_readout_if: request/result bundle between the array host side and
// the sense_readout controller. Parameters must match the attached controller.
interface sense_readout_if #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int ACC_W = 6
);
    localparam int AW = $clog2(ROWS);

    // host / array side to controller
    logic              cs;
    logic              w_en;
    logic              MAC_en;
    logic              acc_clr;
    logic              start;
    logic              BL_dummy;
    logic [COLS-1:0]   SA_out;
    logic [ROWS-1:0]   ML;

    // controller to array / host side
    logic              PRE;
    logic              SAE;
    logic              busy;
    logic              valid;
    logic              timeout_err;
    logic              match_hit;
    logic [AW-1:0]     match_addr;
    logic [ACC_W-1:0]  mac_sum;

    modport master (
        output cs, w_en, MAC_en, acc_clr, start, BL_dummy, SA_out, ML,
        input  PRE, SAE, busy, valid, timeout_err, match_hit, match_addr, mac_sum
    );

    modport slave (
        input  cs, w_en, MAC_en, acc_clr, start, BL_dummy, SA_out, ML,
        output PRE, SAE, busy, valid, timeout_err, match_hit, match_addr, mac_sum
    );
endinterface

// File: rtl/sense_readout.sv
// sense_readout: read-side sequencer for the CAM/MAC bit-cell array.
// Runs precharge -> evaluate -> sense -> capture, self-timed by the dummy
// bitline, and reports either a CAM hit/priority address or a MAC popcount.
// Optional feature macro MAC_ACC_EN: when defined, MAC popcounts accumulate
// (saturating) into mac_sum and acc_clr is honoured; when undefined, mac_sum
// is simply the popcount of the latest MAC operation.
module sense_readout #(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int ACC_W   = 6,
    parameter int PRE_CYC = 2,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    sense_readout_if.slave sr
);
    localparam int AW      = $clog2(ROWS);
    localparam int PC_W    = $clog2(COLS + 1);
    localparam int CNT_MAX = (PRE_CYC > TIMEOUT) ? PRE_CYC : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRECH = 3'd1,
        S_EVAL  = 3'd2,
        S_SENSE = 3'd3,
        S_CAPT  = 3'd4
    } state_t;

    // number of set bits in a sense-amp column vector
    function automatic logic [PC_W-1:0] popcount(input logic [COLS-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < COLS; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    // lowest-index set match line; row 0 wins, 0 when nothing matched
    function automatic logic [AW-1:0] prio_enc(input logic [ROWS-1:0] v);
        logic [AW-1:0] a;
        a = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            a = v[i] ? AW'(i) : a;
        end
        return a;
    endfunction

    state_t            state_r, state_n;
    logic [CNT_W-1:0]  cnt_r;
    logic              bl_meta_r, bl_sync_r;
    logic              done_s;
    logic              accept_s, capture_s, commit_s, timeout_s;
    logic              mode_r;
    logic [ROWS-1:0]   ml_cap_r;
    logic [COLS-1:0]   sa_cap_r;
    logic [PC_W-1:0]   pc_s;
    logic              pre_r, sae_r, busy_r, valid_r, timeout_err_r;
    logic              hit_r;
    logic [AW-1:0]     addr_r;
    logic [ACC_W-1:0]  mac_sum_r;

    // Two-flop synchronizer for the asynchronous dummy bitline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bl_meta_r <= 1'b0;
            bl_sync_r <= 1'b0;
        end else begin
            bl_meta_r <= sr.BL_dummy;
            bl_sync_r <= bl_meta_r;
        end
    end

    // Evaluation is complete once the dummy bitline has discharged.
    assign done_s = ~bl_sync_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic and one-cycle event strobes; chip-select low aborts.
    always_comb begin
        state_n   = state_r;
        accept_s  = 1'b0;
        capture_s = 1'b0;
        commit_s  = 1'b0;
        timeout_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (sr.start && sr.cs && !sr.w_en) begin
                    state_n  = S_PRECH;
                    accept_s = 1'b1;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_PRECH: begin
                if (!sr.cs) begin
                    state_n = S_IDLE;
                end else if (cnt_r == CNT_W'(PRE_CYC - 1)) begin
                    state_n = S_EVAL;
                end else begin
                    state_n = S_PRECH;
                end
            end
            S_EVAL: begin
                if (!sr.cs) begin
                    state_n = S_IDLE;
                end else if (done_s) begin
                    state_n = S_SENSE;
                end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                    state_n   = S_IDLE;
                    timeout_s = 1'b1;
                end else begin
                    state_n = S_EVAL;
                end
            end
            S_SENSE: begin
                if (!sr.cs) begin
                    state_n = S_IDLE;
                end else begin
                    state_n   = S_CAPT;
                    capture_s = 1'b1;
                end
            end
            S_CAPT: begin
                if (!sr.cs) begin
                    state_n = S_IDLE;
                end else begin
                    state_n  = S_IDLE;
                    commit_s = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Cycle counter shared by PRECH and EVAL; restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (state_n != state_r) begin
            cnt_r <= '0;
        end else if (cnt_r != CNT_FULL) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Array controls and status decoded from the next state so they are flop outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_r   <= 1'b0;
            sae_r   <= 1'b0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            pre_r   <= (state_n == S_PRECH);
            sae_r   <= (state_n == S_SENSE);
            busy_r  <= (state_n != S_IDLE);
            valid_r <= commit_s | timeout_s;
        end
    end

    // Operation mode latch and sticky timeout flag (cleared by the next accepted start).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r        <= 1'b0;
            timeout_err_r <= 1'b0;
        end else if (accept_s) begin
            mode_r        <= sr.MAC_en;
            timeout_err_r <= 1'b0;
        end else if (timeout_s) begin
            mode_r        <= mode_r;
            timeout_err_r <= 1'b1;
        end else begin
            mode_r        <= mode_r;
            timeout_err_r <= timeout_err_r;
        end
    end

    // Latch match lines and sense-amp outputs at the end of the SAE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ml_cap_r <= '0;
            sa_cap_r <= '0;
        end else if (capture_s) begin
            ml_cap_r <= sr.ML;
            sa_cap_r <= sr.SA_out;
        end else begin
            ml_cap_r <= ml_cap_r;
            sa_cap_r <= sa_cap_r;
        end
    end

    assign pc_s = popcount(sa_cap_r);

    // CAM result registers, updated only by a completed CAM operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_r  <= 1'b0;
            addr_r <= '0;
        end else if (commit_s && !mode_r) begin
            hit_r  <= |ml_cap_r;
            addr_r <= prio_enc(ml_cap_r);
        end else begin
            hit_r  <= hit_r;
            addr_r <= addr_r;
        end
    end

`ifdef MAC_ACC_EN
    localparam int SUM_W = ((ACC_W > PC_W) ? ACC_W : PC_W) + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    logic [SUM_W-1:0] sum_s;
    logic [ACC_W-1:0] sat_s;

    // Saturating accumulate of the current popcount.
    always_comb begin
        sum_s = SUM_W'(mac_sum_r) + SUM_W'(pc_s);
        if (sum_s > SUM_W'(ACC_MAX)) begin
            sat_s = ACC_MAX;
        end else begin
            sat_s = sum_s[ACC_W-1:0];
        end
    end

    // Accumulator; a clear coinciding with a MAC capture restarts from this popcount.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_sum_r <= '0;
        end else if (commit_s && mode_r) begin
            mac_sum_r <= sr.acc_clr ? ACC_W'(pc_s) : sat_s;
        end else if (sr.acc_clr) begin
            mac_sum_r <= '0;
        end else begin
            mac_sum_r <= mac_sum_r;
        end
    end
`else
    logic unused_acc_clr_s;
    assign unused_acc_clr_s = sr.acc_clr;

    // Without accumulation mac_sum reports the popcount of the latest MAC operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_sum_r <= '0;
        end else if (commit_s && mode_r) begin
            mac_sum_r <= ACC_W'(pc_s);
        end else begin
            mac_sum_r <= mac_sum_r;
        end
    end
`endif

    assign sr.PRE         = pre_r;
    assign sr.SAE         = sae_r;
    assign sr.busy        = busy_r;
    assign sr.valid       = valid_r;
    assign sr.timeout_err = timeout_err_r;
    assign sr.match_hit   = hit_r;
    assign sr.match_addr  = addr_r;
    assign sr.mac_sum     = mac_sum_r;

endmodule

// File: tb/tb_sense_readout.sv
// tb_sense_readout: table-driven directed vectors plus randomized operations
// checked against a transaction-level model, on two instances (ACC_W 6 and 3).
module tb_sense_readout;
    localparam int PRE_CYC = 2;
    localparam int TIMEOUT = 15;
`ifdef MAC_ACC_EN
    localparam bit ACC_ON = 1'b1;
`else
    localparam bit ACC_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       cs = 1'b1, w_en = 1'b0, mac_en = 1'b0, acc_clr = 1'b0, start = 1'b0, bl = 1'b1;
    logic [3:0] sa = 4'b0000, ml = 4'b0000;

    sense_readout_if #(.ROWS(4), .COLS(4), .ACC_W(6)) if_a ();
    sense_readout_if #(.ROWS(4), .COLS(4), .ACC_W(3)) if_b ();

    assign if_a.cs = cs;      assign if_b.cs = cs;
    assign if_a.w_en = w_en;  assign if_b.w_en = w_en;
    assign if_a.MAC_en = mac_en;   assign if_b.MAC_en = mac_en;
    assign if_a.acc_clr = acc_clr; assign if_b.acc_clr = acc_clr;
    assign if_a.start = start; assign if_b.start = start;
    assign if_a.BL_dummy = bl; assign if_b.BL_dummy = bl;
    assign if_a.SA_out = sa;  assign if_b.SA_out = sa;
    assign if_a.ML = ml;      assign if_b.ML = ml;

    sense_readout #(.ROWS(4), .COLS(4), .ACC_W(6), .PRE_CYC(PRE_CYC), .TIMEOUT(TIMEOUT))
        dut_a (.clk(clk), .rst_n(rst_n), .sr(if_a.slave));
    sense_readout #(.ROWS(4), .COLS(4), .ACC_W(3), .PRE_CYC(PRE_CYC), .TIMEOUT(TIMEOUT))
        dut_b (.clk(clk), .rst_n(rst_n), .sr(if_b.slave));

    int tests = 0;
    int fails = 0;

    // reference model state (results as seen after the latest operation)
    bit m_hit = 1'b0;
    int m_addr = 0, m_sa = 0, m_sb = 0;
    bit m_to = 1'b0;

    typedef struct {
        bit         mode;
        logic [3:0] sa;
        logic [3:0] ml;
        int         j;      // EVAL cycle at which BL_dummy falls, -1 = never
        int         clr;    // 0 none, 1 acc_clr before start, 2 acc_clr in CAPT cycle
        bit         e_hit;
        int         e_addr;
        int         e_sa;
        int         e_sb;
        bit         e_to;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_results(input string tag, input bit e_hit, input int e_addr,
                                 input int e_sa, input int e_sb, input bit e_to);
        check({tag, " hit_a"}, 32'(if_a.match_hit), 32'(e_hit));
        check({tag, " addr_a"}, 32'(if_a.match_addr), e_addr);
        check({tag, " sum_a"}, 32'(if_a.mac_sum), e_sa);
        check({tag, " to_a"}, 32'(if_a.timeout_err), 32'(e_to));
        check({tag, " hit_b"}, 32'(if_b.match_hit), 32'(e_hit));
        check({tag, " addr_b"}, 32'(if_b.match_addr), e_addr);
        check({tag, " sum_b"}, 32'(if_b.mac_sum), e_sb);
        check({tag, " to_b"}, 32'(if_b.timeout_err), 32'(e_to));
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Transaction-level reference: result registers after one complete operation.
    task automatic model_op(input bit mode, input logic [3:0] sa_v, input logic [3:0] ml_v,
                            input int j, input int clr);
        int pc;
        pc = $countones(sa_v);
        if (ACC_ON && clr == 1) begin m_sa = 0; m_sb = 0; end
        if (j < 0) begin
            m_to = 1'b1;
            if (ACC_ON && clr == 2) begin m_sa = 0; m_sb = 0; end
        end else begin
            m_to = 1'b0;
            if (!mode) begin
                m_hit = (ml_v != 4'b0000);
                m_addr = 0;
                for (int r = 3; r >= 0; r--) if (ml_v[r]) m_addr = r;
                if (ACC_ON && clr == 2) begin m_sa = 0; m_sb = 0; end
            end else if (!ACC_ON || clr == 2) begin
                m_sa = pc; m_sb = pc;
            end else begin
                m_sa = sat(m_sa + pc, 63); m_sb = sat(m_sb + pc, 7);
            end
        end
    endtask

    // Issue one operation, drive the dummy bitline, check timing and results.
    task automatic run_op(input string tag, input bit mode, input logic [3:0] sa_v,
                          input logic [3:0] ml_v, input int j, input int clr, input bit dbl,
                          input bit e_hit, input int e_addr, input int e_sa, input int e_sb,
                          input bit e_to);
        int exp_c, pre_n, sae_n, val_n;
        if (clr == 1) begin acc_clr = 1'b1; tick(); acc_clr = 1'b0; end
        mac_en = mode; sa = sa_v; ml = ml_v; start = 1'b1;
        tick();
        start = 1'b0;
        exp_c = (j < 0) ? PRE_CYC + TIMEOUT : PRE_CYC + j + 5;
        pre_n = 0; sae_n = 0; val_n = 0;
        for (int c = 0; c <= exp_c + 4; c++) begin
            if (c == 0) check({tag, " busy_on"}, 32'(if_a.busy), 32'd1);
            pre_n += int'(if_a.PRE);
            sae_n += int'(if_a.SAE);
            val_n += int'(if_a.valid);
            if (c == exp_c) begin
                check({tag, " valid_a"}, 32'(if_a.valid), 32'd1);
                check({tag, " valid_b"}, 32'(if_b.valid), 32'd1);
                check({tag, " busy_off"}, 32'(if_a.busy), 32'd0);
                check_results(tag, e_hit, e_addr, e_sa, e_sb, e_to);
            end
            if (j >= 0 && c == PRE_CYC + j) bl = 1'b0;
            if (c == exp_c) bl = 1'b1;
            acc_clr = (clr == 2 && c == exp_c - 1);
            start = (dbl && c == 1);
            tick();
        end
        check({tag, " pre_cycles"}, pre_n, PRE_CYC);
        check({tag, " sae_cycles"}, sae_n, (j >= 0) ? 1 : 0);
        check({tag, " valid_count"}, val_n, 1);
    endtask

    // Watch a window of cycles and count valid pulses.
    task automatic count_valid(input int n, output int cnt);
        cnt = 0;
        for (int c = 0; c < n; c++) begin
            cnt += int'(if_a.valid) + int'(if_b.valid);
            tick();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt;
        bit r_mode; logic [3:0] r_sa, r_ml; int r_j, r_clr;

        // expected values hand-derived from the operation rules
        tbl[0]  = '{1'b0, 4'b0000, 4'b0110,  3, 0, 1'b1, 1, 0, 0, 1'b0};
        tbl[1]  = '{1'b1, 4'b1011, 4'b0000,  0, 1, 1'b1, 1, 3, 3, 1'b0};
        tbl[2]  = '{1'b1, 4'b1111, 4'b0000,  2, 0, 1'b1, 1, ACC_ON ? 7 : 4, ACC_ON ? 7 : 4, 1'b0};
        tbl[3]  = '{1'b1, 4'b0001, 4'b0000,  1, 0, 1'b1, 1, ACC_ON ? 8 : 1, ACC_ON ? 7 : 1, 1'b0};
        tbl[4]  = '{1'b0, 4'b1111, 4'b0000,  5, 0, 1'b0, 0, ACC_ON ? 8 : 1, ACC_ON ? 7 : 1, 1'b0};
        tbl[5]  = '{1'b0, 4'b0000, 4'b1111,  0, 0, 1'b1, 0, ACC_ON ? 8 : 1, ACC_ON ? 7 : 1, 1'b0};
        tbl[6]  = '{1'b0, 4'b0000, 4'b1000, 10, 0, 1'b1, 3, ACC_ON ? 8 : 1, ACC_ON ? 7 : 1, 1'b0};
        tbl[7]  = '{1'b0, 4'b1111, 4'b0101, -1, 0, 1'b1, 3, ACC_ON ? 8 : 1, ACC_ON ? 7 : 1, 1'b1};
        tbl[8]  = '{1'b1, 4'b1111, 4'b0000,  4, 0, 1'b1, 3, ACC_ON ? 12 : 4, ACC_ON ? 7 : 4, 1'b0};
        tbl[9]  = '{1'b0, 4'b0000, 4'b0100,  0, 0, 1'b1, 2, ACC_ON ? 12 : 4, ACC_ON ? 7 : 4, 1'b0};
        tbl[10] = '{1'b1, 4'b1111, 4'b0000,  3, 1, 1'b1, 2, 4, 4, 1'b0};
        tbl[11] = '{1'b1, 4'b1111, 4'b0000,  1, 0, 1'b1, 2, ACC_ON ? 8 : 4, ACC_ON ? 7 : 4, 1'b0};
        tbl[12] = '{1'b1, 4'b0111, 4'b0000,  1, 2, 1'b1, 2, 3, 3, 1'b0};

        // reset state
        tick(); tick();
        check("rst PRE", 32'(if_a.PRE), 32'd0);
        check("rst SAE", 32'(if_a.SAE), 32'd0);
        check("rst busy", 32'(if_a.busy), 32'd0);
        check("rst valid", 32'(if_a.valid), 32'd0);
        check_results("rst", 1'b0, 0, 0, 0, 1'b0);
        rst_n = 1'b1;
        tick(); tick(); tick(); tick();

        for (int i = 0; i < 13; i++) begin
            model_op(tbl[i].mode, tbl[i].sa, tbl[i].ml, tbl[i].j, tbl[i].clr);
            run_op($sformatf("vec%0d", i), tbl[i].mode, tbl[i].sa, tbl[i].ml, tbl[i].j,
                   tbl[i].clr, 1'b0, tbl[i].e_hit, tbl[i].e_addr, tbl[i].e_sa, tbl[i].e_sb,
                   tbl[i].e_to);
        end

        for (int i = 0; i < 40; i++) begin
            r_mode = 1'($urandom_range(0, 1));
            r_sa   = 4'($urandom_range(0, 15));
            r_ml   = 4'($urandom_range(0, 15));
            r_j    = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 10));
            r_clr  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
            model_op(r_mode, r_sa, r_ml, r_j, r_clr);
            run_op($sformatf("rnd%0d", i), r_mode, r_sa, r_ml, r_j, r_clr, 1'b0,
                   m_hit, m_addr, m_sa, m_sb, m_to);
        end

        // cs dropped during precharge: abort, no valid, results held
        mac_en = 1'b0; ml = 4'b1111; start = 1'b1;
        tick();
        start = 1'b0;
        check("cs_abort PRE_on", 32'(if_a.PRE), 32'd1);
        cs = 1'b0;
        tick();
        check("cs_abort PRE_off", 32'(if_a.PRE), 32'd0);
        check("cs_abort busy_off", 32'(if_a.busy), 32'd0);
        count_valid(25, vcnt);
        check("cs_abort no_valid", vcnt, 0);
        cs = 1'b1;
        m_to = 1'b0;
        check_results("cs_abort held", m_hit, m_addr, m_sa, m_sb, m_to);
        tick(); tick();

        // start during a write cycle is dropped
        w_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("w_en busy", 32'(if_a.busy), 32'd0);
        count_valid(25, vcnt);
        check("w_en no_valid", vcnt, 0);
        w_en = 1'b0;
        tick();

        // second start while busy is ignored
        model_op(1'b1, 4'b0011, 4'b0000, 2, 0);
        run_op("dbl_start", 1'b1, 4'b0011, 4'b0000, 2, 0, 1'b1, m_hit, m_addr, m_sa, m_sb, m_to);
        count_valid(25, vcnt);
        check("dbl_start no_extra_valid", vcnt, 0);

        // reset asserted mid-EVAL
        mac_en = 1'b0; ml = 4'b0010; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < PRE_CYC + 3; c++) tick();
        rst_n = 1'b0;
        #1;
        check("rst_eval PRE", 32'(if_a.PRE), 32'd0);
        check("rst_eval SAE", 32'(if_a.SAE), 32'd0);
        check("rst_eval busy", 32'(if_a.busy), 32'd0);
        check("rst_eval valid", 32'(if_a.valid), 32'd0);
        check_results("rst_eval", 1'b0, 0, 0, 0, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("rst_eval idle", 32'(if_a.busy), 32'd0);
        m_hit = 1'b0; m_addr = 0; m_sa = 0; m_sb = 0; m_to = 1'b0;
        model_op(1'b0, 4'b0000, 4'b1010, 1, 0);
        run_op("post_rst", 1'b0, 4'b0000, 4'b1010, 1, 0, 1'b0, m_hit, m_addr, m_sa, m_sb, m_to);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
